// File: rtl/jk_counter_pkg.sv
// Shared constants for the JK-based up/down counter: default geometry,
// direction encoding and the per-edge operation selector.
package jk_counter_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // What the counter does on the coming edge (reset handled separately).
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2
  } op_e;

  // Priority decode of the strobes: load beats enable.
  function automatic op_e decode_op(input logic load, input logic en);
    if (load)    return OP_LOAD;
    else if (en) return OP_COUNT;
    else         return OP_HOLD;
  endfunction

endpackage

// File: rtl/jk_updown_counter_if.sv
// Control/status bundle of the up/down counter. The master drives the
// strobes and load value; the slave (the counter) returns count and flags.
interface jk_updown_counter_if
  import jk_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up, load, load_val,
    input  count, tc, wrap, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tc, wrap, load_err
  );

endinterface

// File: rtl/jk_ff_bit.sv
// One JK flip-flop cell with synchronous active-high reset.
// j/k = 00 hold, 01 clear, 10 set, 11 toggle.
module jk_ff_bit (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK state update; reset overrides j/k on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00: q <= q;
        2'b01: q <= 1'b0;
        2'b10: q <= 1'b1;
        2'b11: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter built from JK flip-flop cells. The next
// value is computed behaviourally and translated into per-bit J/K drives;
// wrap and load_err are one-cycle registered pulses.
module jk_updown_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic                clk,
  input  logic                reset,
  jk_updown_counter_if.slave  bus
);

  // Comparisons are done at full counter width (or one bit wider for the
  // load range check) so MODULUS = 2^WIDTH never overflows.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             at_max;
  logic             at_zero;
  logic             load_oor;
  logic             next_wrap;
  logic             next_err;
  logic             wrap_q;
  logic             err_q;
  op_e              op;

  assign at_max   = (count_q == MAX_CNT);
  assign at_zero  = (count_q == '0);
  assign load_oor = ({1'b0, bus.load_val} >= MOD_EXT);
  assign op       = decode_op(bus.load, bus.en);

  // Next-state selection: load (clamped when out of range), count with
  // modulo wrap in either direction, or hold.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    next_count = count_q;
    next_wrap  = 1'b0;
    next_err   = 1'b0;
    unique case (op)
      OP_LOAD: begin
        if (load_oor) begin
          next_count = MAX_CNT;
          next_err   = 1'b1;
        end else begin
          next_count = bus.load_val;
        end
      end
      OP_COUNT: begin
        if (bus.up == DIR_UP) begin
          if (at_max) begin
            next_count = '0;
            next_wrap  = 1'b1;
          end else begin
            next_count = count_q + 1'b1;
          end
        end else begin
          if (at_zero) begin
            next_count = MAX_CNT;
            next_wrap  = 1'b1;
          end else begin
            next_count = count_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Set bits that must rise, clear bits that must fall, hold the rest.
  assign j_vec = ~count_q & next_count;
  assign k_vec = count_q & ~next_count;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_bit u_bit (
      .clk   (clk),
      .reset (reset),
      .j     (j_vec[i]),
      .k     (k_vec[i]),
      .q     (count_q[i])
    );
  end

  // Registered status pulses; next_wrap and next_err are mutually exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= next_wrap;
      err_q  <= next_err;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;
  assign bus.tc       = bus.en & ~bus.load &
                        ((bus.up & at_max) | (~bus.up & at_zero));

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed table-driven bench for jk_updown_counter (WIDTH=4, MODULUS=10),
// plus hand sequences for zero-latency tc and the en=0 hold case.
module tb_jk_updown_counter;

  logic clk;
  logic reset;

  jk_updown_counter_if #(.WIDTH(4)) bus ();

  jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic       en;
    logic       up;
    logic [3:0] lv;
    logic       tc;   // expected tc with these inputs, before the edge
    logic [3:0] cnt;  // expected count after the edge
    logic       wr;   // expected wrap after the edge
    logic       er;   // expected load_err after the edge
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic rst, logic ld, logic en, logic up,
                              logic [3:0] lv, logic tc, logic [3:0] cnt,
                              logic wr, logic er);
    vec_t v;
    v.rst = rst; v.ld = ld; v.en = en; v.up = up; v.lv = lv;
    v.tc = tc; v.cnt = cnt; v.wr = wr; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, check tc, clock, check results.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset        = v.rst;
    bus.load     = v.ld;
    bus.en       = v.en;
    bus.up       = v.up;
    bus.load_val = v.lv;
    #1;
    check({tag, " tc"}, 32'(bus.tc), 32'(v.tc));
    @(posedge clk);
    #1;
    check({tag, " count"}, 32'(bus.count), 32'(v.cnt));
    check({tag, " wrap"}, 32'(bus.wrap), 32'(v.wr));
    check({tag, " load_err"}, 32'(bus.load_err), 32'(v.er));
    check({tag, " excl"}, 32'(bus.wrap & bus.load_err), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = '0;

    //          rst ld en up lv     tc cnt   wr er
    // Reset wins over load and en.
    vecs.push_back(mk(1, 1, 1, 1, 4'd7, 0, 4'd0, 0, 0));
    // Count up 12 edges: 1..9, 0, 1, 2.
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(0, 0, 1, 1, 4'd0, 0, 4'(i + 1), 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd0, 1, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd0, 0, 4'd1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd0, 0, 4'd2, 0, 0));
    // Load 9, then reset on a would-wrap edge.
    vecs.push_back(mk(0, 1, 0, 1, 4'd9, 0, 4'd9, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 4'd0, 1, 4'd0, 0, 0));
    // Count down 3 edges: 9, 8, 7.
    vecs.push_back(mk(0, 0, 1, 0, 4'd0, 1, 4'd9, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd0, 0, 4'd8, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd0, 0, 4'd7, 0, 0));
    // Load wins over en; out-of-range loads clamp and flag for one cycle.
    vecs.push_back(mk(0, 1, 1, 1, 4'd5, 0, 4'd5, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 4'd12, 0, 4'd9, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 4'd3, 0, 4'd9, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'd15, 0, 4'd9, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 4'd10, 0, 4'd9, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0));
    // Alternate direction every edge from 0: 9, 0, 9, 0, all wrapping.
    vecs.push_back(mk(0, 0, 1, 0, 4'd0, 1, 4'd9, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd0, 1, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd0, 1, 4'd9, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd0, 1, 4'd0, 1, 0));
    // Idle after a wrap clears the pulse.
    vecs.push_back(mk(0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0));

    foreach (vecs[i])
      apply(vecs[i], $sformatf("vec%0d", i));

    // tc follows up/load/en immediately with count parked at 0.
    @(negedge clk);
    bus.en = 1'b1; bus.up = 1'b1; bus.load = 1'b0;
    #1 check("tc zl up@0", 32'(bus.tc), 32'd0);
    bus.up = 1'b0;
    #1 check("tc zl down@0", 32'(bus.tc), 32'd1);
    bus.load = 1'b1;
    #1 check("tc zl load", 32'(bus.tc), 32'd0);
    bus.load = 1'b0; bus.en = 1'b0;
    #1 check("tc zl en0", 32'(bus.tc), 32'd0);

    // Hold at 4 for 5 edges with random direction and load value.
    apply(mk(0, 1, 0, 1, 4'd4, 0, 4'd4, 0, 0), "ld4");
    for (int i = 0; i < 5; i++)
      apply(mk(0, 0, 0, 1'($urandom_range(0, 1)), 4'($urandom), 0, 4'd4,
               0, 0), $sformatf("hold%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
